// File: rtl/control_unit.sv
// Multicycle CPU control unit.
// Moore FSM: every datapath control wire is decoded from the registered
// state (state_q plus the held exception cause and mult/div selector).
// Opcode, funct and the datapath status flags only steer the next state.
module control_unit #(
    parameter int MULT_CYCLES = 32,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Flag_Overflow,
    input  logic       divPor0,
    output logic       PC_W,
    output logic       PCWriteCond,
    output logic [2:0] PCSource,
    output logic [1:0] IorD,
    output logic       Mem_W,
    output logic       MDR_W,
    output logic       IR_W,
    output logic       RB_W,
    output logic [1:0] regDST,
    output logic [2:0] memToReg,
    output logic       Reg_AB_W,
    output logic       ALU_Out_Reg_W,
    output logic [1:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] CB,
    output logic       HILO_W,
    output logic       divOrMult,
    output logic       controlDivMult,
    output logic       EPC_W,
    output logic [1:0] EC_CTRL
);

    // Counter must hold the larger of the two operation lengths.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // State encoding
    localparam logic [4:0] S_RESET    = 5'd0;
    localparam logic [4:0] S_FETCH0   = 5'd1;
    localparam logic [4:0] S_FETCH1   = 5'd2;
    localparam logic [4:0] S_DECODE   = 5'd3;
    localparam logic [4:0] S_R_ADD    = 5'd4;
    localparam logic [4:0] S_R_SUB    = 5'd5;
    localparam logic [4:0] S_R_AND    = 5'd6;
    localparam logic [4:0] S_R_WB     = 5'd7;
    localparam logic [4:0] S_R_SLT    = 5'd8;
    localparam logic [4:0] S_ADDI     = 5'd9;
    localparam logic [4:0] S_ADDI_WB  = 5'd10;
    localparam logic [4:0] S_ADDR_LW  = 5'd11;
    localparam logic [4:0] S_ADDR_SW  = 5'd12;
    localparam logic [4:0] S_RD0      = 5'd13;
    localparam logic [4:0] S_RD1      = 5'd14;
    localparam logic [4:0] S_LW_WB    = 5'd15;
    localparam logic [4:0] S_ST       = 5'd16;
    localparam logic [4:0] S_BEQ      = 5'd17;
    localparam logic [4:0] S_BNE      = 5'd18;
    localparam logic [4:0] S_J        = 5'd19;
    localparam logic [4:0] S_JAL      = 5'd20;
    localparam logic [4:0] S_JR       = 5'd21;
    localparam logic [4:0] S_MD0      = 5'd22;
    localparam logic [4:0] S_MD_WAIT  = 5'd23;
    localparam logic [4:0] S_MD_DONE  = 5'd24;
    localparam logic [4:0] S_MFHI     = 5'd25;
    localparam logic [4:0] S_MFLO     = 5'd26;
    localparam logic [4:0] S_EXC0     = 5'd27;
    localparam logic [4:0] S_EXC1     = 5'd28;
    localparam logic [4:0] S_EXC2     = 5'd29;

    // Exception cause codes
    localparam logic [1:0] EC_INVALID  = 2'd0;
    localparam logic [1:0] EC_OVERFLOW = 2'd1;
    localparam logic [1:0] EC_DIVZERO  = 2'd2;

    // ALU operations
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_CMP = 3'b111;

    logic [4:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_mult_q, md_mult_d;   // 1: multiplier in use, 0: divider
    logic [1:0]       ec_q, ec_d;             // cause held through EXC0..EXC2
    logic [CNT_W-1:0] cnt_dec;

    assign cnt_dec = cnt_q - CNT_ONE;

    // State register with synchronous reset; reset also aborts a running countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_RESET;
            cnt_q     <= '0;
            md_mult_q <= 1'b0;
            ec_q      <= EC_INVALID;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_mult_q <= md_mult_d;
            ec_q      <= ec_d;
        end
    end

    // Next-state logic: instruction dispatch, overflow/div-by-zero traps, mult/div countdown.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        md_mult_d = md_mult_q;
        ec_d      = ec_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH0;
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == 6'h00) begin
                    case (funct)
                        6'h20: state_d = S_R_ADD;
                        6'h22: state_d = S_R_SUB;
                        6'h24: state_d = S_R_AND;
                        6'h2A: state_d = S_R_SLT;
                        6'h08: state_d = S_JR;
                        6'h18: begin state_d = S_MD0; md_mult_d = 1'b1; end
                        6'h1A: begin state_d = S_MD0; md_mult_d = 1'b0; end
                        6'h10: state_d = S_MFHI;
                        6'h12: state_d = S_MFLO;
                        default: begin state_d = S_EXC0; ec_d = EC_INVALID; end
                    endcase
                end else begin
                    case (opcode)
                        6'h08: state_d = S_ADDI;
                        6'h23: state_d = S_ADDR_LW;
                        6'h2B: state_d = S_ADDR_SW;
                        6'h04: state_d = S_BEQ;
                        6'h05: state_d = S_BNE;
                        6'h02: state_d = S_J;
                        6'h03: state_d = S_JAL;
                        default: begin state_d = S_EXC0; ec_d = EC_INVALID; end
                    endcase
                end
            end
            S_R_ADD, S_R_SUB: begin
                if (Flag_Overflow) begin
                    state_d = S_EXC0;
                    ec_d    = EC_OVERFLOW;
                end else begin
                    state_d = S_R_WB;
                end
            end
            S_R_AND:  state_d = S_R_WB;
            S_ADDI: begin
                if (Flag_Overflow) begin
                    state_d = S_EXC0;
                    ec_d    = EC_OVERFLOW;
                end else begin
                    state_d = S_ADDI_WB;
                end
            end
            S_ADDR_LW: state_d = S_RD0;
            S_ADDR_SW: state_d = S_ST;
            S_RD0:     state_d = S_RD1;
            S_RD1:     state_d = S_LW_WB;
            S_MD0: begin
                cnt_d = md_mult_q ? MULT_LOAD : DIV_LOAD;
                if (!md_mult_q && divPor0) begin
                    state_d = S_EXC0;
                    ec_d    = EC_DIVZERO;
                end else if (cnt_d == CNT_ONE) begin
                    // Single-cycle unit: HILO_W lands one cycle after MD0.
                    state_d = S_MD_DONE;
                end else begin
                    state_d = S_MD_WAIT;
                end
            end
            S_MD_WAIT: begin
                cnt_d = cnt_dec;
                if (cnt_dec == CNT_ONE) begin
                    state_d = S_MD_DONE;
                end
            end
            S_EXC0: state_d = S_EXC1;
            S_EXC1: state_d = S_EXC2;
            // Terminal states all return to fetch.
            S_R_WB, S_R_SLT, S_ADDI_WB, S_LW_WB, S_ST, S_BEQ, S_BNE,
            S_J, S_JAL, S_JR, S_MD_DONE, S_MFHI, S_MFLO, S_EXC2:
                state_d = S_FETCH0;
            default: state_d = S_FETCH0;
        endcase
    end

    // Output decode from the registered state only.
    always_comb begin
        PC_W           = 1'b0;
        PCWriteCond    = 1'b0;
        PCSource       = 3'd0;
        IorD           = 2'd0;
        Mem_W          = 1'b0;
        MDR_W          = 1'b0;
        IR_W           = 1'b0;
        RB_W           = 1'b0;
        regDST         = 2'd0;
        memToReg       = 3'd0;
        Reg_AB_W       = 1'b0;
        ALU_Out_Reg_W  = 1'b0;
        ALUSrcA        = 2'd0;
        ALUSrcB        = 3'd0;
        ALUControl     = 3'b000;
        CB             = 2'd0;
        HILO_W         = 1'b0;
        divOrMult      = 1'b0;
        controlDivMult = 1'b0;
        EPC_W          = 1'b0;
        EC_CTRL        = 2'd0;
        case (state_q)
            S_FETCH1: begin
                // PC <= PC + 4 while the instruction is latched.
                IR_W       = 1'b1;
                PC_W       = 1'b1;
                PCSource   = 3'd2;
                ALUSrcA    = 2'd0;
                ALUSrcB    = 3'd4;
                ALUControl = ALU_ADD;
            end
            S_DECODE: begin
                // Latch A/B and precompute the branch target.
                Reg_AB_W      = 1'b1;
                ALU_Out_Reg_W = 1'b1;
                ALUSrcA       = 2'd0;
                ALUSrcB       = 3'd3;
                ALUControl    = ALU_ADD;
            end
            S_R_ADD, S_R_SUB, S_R_AND: begin
                ALUSrcA       = 2'd2;
                ALUSrcB       = 3'd0;
                ALU_Out_Reg_W = 1'b1;
                ALUControl    = (state_q == S_R_ADD) ? ALU_ADD :
                                (state_q == S_R_SUB) ? ALU_SUB : ALU_AND;
            end
            S_R_WB: begin
                RB_W     = 1'b1;
                regDST   = 2'd1;
                memToReg = 3'd5;
            end
            S_R_SLT: begin
                ALUSrcA    = 2'd2;
                ALUSrcB    = 3'd0;
                ALUControl = ALU_CMP;
                RB_W       = 1'b1;
                regDST     = 2'd1;
                memToReg   = 3'd1;
            end
            S_ADDI, S_ADDR_LW, S_ADDR_SW: begin
                // Reg_A + sign-extended immediate into ALUOut.
                ALUSrcA       = 2'd2;
                ALUSrcB       = 3'd1;
                ALUControl    = ALU_ADD;
                ALU_Out_Reg_W = 1'b1;
            end
            S_ADDI_WB: begin
                RB_W     = 1'b1;
                regDST   = 2'd0;
                memToReg = 3'd5;
            end
            S_RD0: IorD = 2'd1;
            S_RD1: begin
                IorD  = 2'd1;
                MDR_W = 1'b1;
            end
            S_LW_WB: begin
                RB_W     = 1'b1;
                regDST   = 2'd0;
                memToReg = 3'd4;
            end
            S_ST: begin
                IorD  = 2'd1;
                Mem_W = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA     = 2'd2;
                ALUSrcB     = 3'd0;
                ALUControl  = ALU_CMP;
                PCWriteCond = 1'b1;
                PCSource    = 3'd4;
                CB          = (state_q == S_BNE) ? 2'd1 : 2'd0;
            end
            S_J: begin
                PC_W     = 1'b1;
                PCSource = 3'd0;
            end
            S_JAL: begin
                // PC already holds PC+4, which is the link value.
                PC_W     = 1'b1;
                PCSource = 3'd0;
                RB_W     = 1'b1;
                regDST   = 2'd2;
                memToReg = 3'd0;
            end
            S_JR: begin
                PC_W     = 1'b1;
                PCSource = 3'd1;
            end
            S_MD0, S_MD_WAIT: divOrMult = md_mult_q;
            S_MD_DONE: begin
                divOrMult = md_mult_q;
                HILO_W    = 1'b1;
            end
            S_MFHI, S_MFLO: begin
                RB_W           = 1'b1;
                regDST         = 2'd1;
                memToReg       = 3'd3;
                controlDivMult = (state_q == S_MFHI);
            end
            S_EXC0: begin
                EPC_W   = 1'b1;
                IorD    = 2'd2;
                EC_CTRL = ec_q;
            end
            S_EXC1: begin
                IorD    = 2'd2;
                MDR_W   = 1'b1;
                EC_CTRL = ec_q;
            end
            S_EXC2: begin
                PC_W     = 1'b1;
                PCSource = 3'd5;
                EC_CTRL  = ec_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed checks with literal expectations,
// then randomized opcode/funct/flag/reset stimulus compared every cycle
// against an instruction-cycle-count model of the controller.
module tb_control_unit;

    localparam int N_MULT = 32;
    localparam int N_DIV  = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       Flag_Overflow, divPor0;
    logic       PC_W, PCWriteCond, Mem_W, MDR_W, IR_W, RB_W, Reg_AB_W, ALU_Out_Reg_W;
    logic       HILO_W, divOrMult, controlDivMult, EPC_W;
    logic [2:0] PCSource, memToReg, ALUSrcB, ALUControl;
    logic [1:0] IorD, regDST, ALUSrcA, CB, EC_CTRL;

    always #5 clk = ~clk;

    control_unit #(.MULT_CYCLES(N_MULT), .DIV_CYCLES(N_DIV)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .Flag_Overflow(Flag_Overflow), .divPor0(divPor0),
        .PC_W(PC_W), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
        .Mem_W(Mem_W), .MDR_W(MDR_W), .IR_W(IR_W), .RB_W(RB_W), .regDST(regDST),
        .memToReg(memToReg), .Reg_AB_W(Reg_AB_W), .ALU_Out_Reg_W(ALU_Out_Reg_W),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .CB(CB),
        .HILO_W(HILO_W), .divOrMult(divOrMult), .controlDivMult(controlDivMult),
        .EPC_W(EPC_W), .EC_CTRL(EC_CTRL)
    );

    typedef struct packed {
        logic       pc_w;
        logic       pcwc;
        logic [2:0] pcsrc;
        logic [1:0] iord;
        logic       mem_w;
        logic       mdr_w;
        logic       ir_w;
        logic       rb_w;
        logic [1:0] regdst;
        logic [2:0] m2r;
        logic       ab_w;
        logic       aluout_w;
        logic [1:0] srca;
        logic [2:0] srcb;
        logic [2:0] aluc;
        logic [1:0] cb;
        logic       hilo_w;
        logic       dom;
        logic       cdm;
        logic       epc_w;
        logic [1:0] ec;
    } out_t;

    out_t act;
    assign act = {PC_W, PCWriteCond, PCSource, IorD, Mem_W, MDR_W, IR_W, RB_W, regDST,
                  memToReg, Reg_AB_W, ALU_Out_Reg_W, ALUSrcA, ALUSrcB, ALUControl, CB,
                  HILO_W, divOrMult, controlDivMult, EPC_W, EC_CTRL};

    int checks   = 0;
    int failures = 0;

    // Instruction kinds
    localparam int K_ADD = 0,  K_SUB = 1,  K_AND = 2,  K_SLT = 3,  K_JR = 4,  K_MULT = 5;
    localparam int K_DIV = 6,  K_MFHI = 7, K_MFLO = 8, K_ADDI = 9, K_LW = 10, K_SW = 11;
    localparam int K_BEQ = 12, K_BNE = 13, K_J = 14,   K_JAL = 15, K_INV = 16;

    function automatic int decode(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            case (fn)
                6'h20: return K_ADD;
                6'h22: return K_SUB;
                6'h24: return K_AND;
                6'h2A: return K_SLT;
                6'h08: return K_JR;
                6'h18: return K_MULT;
                6'h1A: return K_DIV;
                6'h10: return K_MFHI;
                6'h12: return K_MFLO;
                default: return K_INV;
            endcase
        end
        case (op)
            6'h08: return K_ADDI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_INV;
        endcase
    endfunction

    // Total cycles of an instruction counted from its fetch cycle.
    function automatic int instr_len(input int kind);
        case (kind)
            K_ADD, K_SUB, K_AND, K_ADDI, K_SW: return 5;
            K_LW:   return 7;
            K_MULT: return 4 + N_MULT;
            K_DIV:  return 4 + N_DIV;
            default: return 4;
        endcase
    endfunction

    // Expected control word for cycle k of an instruction (or exception cycle exc).
    function automatic out_t expect_out(input bit rst, input int exc, input logic [1:0] ec,
                                        input int kind, input int k);
        out_t o;
        o = '0;
        if (rst) return o;
        if (exc != 0) begin
            o.ec = ec;
            if (exc == 1) begin o.epc_w = 1'b1; o.iord = 2'd2; end
            if (exc == 2) begin o.mdr_w = 1'b1; o.iord = 2'd2; end
            if (exc == 3) begin o.pc_w = 1'b1; o.pcsrc = 3'd5; end
            return o;
        end
        if (k == 2) begin
            o.ir_w = 1'b1; o.pc_w = 1'b1; o.pcsrc = 3'd2; o.srcb = 3'd4; o.aluc = 3'b001;
        end else if (k == 3) begin
            o.ab_w = 1'b1; o.aluout_w = 1'b1; o.srcb = 3'd3; o.aluc = 3'b001;
        end else if (k >= 4) begin
            case (kind)
                K_ADD, K_SUB, K_AND: begin
                    if (k == 4) begin
                        o.srca = 2'd2; o.aluout_w = 1'b1;
                        o.aluc = (kind == K_ADD) ? 3'b001 : (kind == K_SUB) ? 3'b010 : 3'b011;
                    end else begin
                        o.rb_w = 1'b1; o.regdst = 2'd1; o.m2r = 3'd5;
                    end
                end
                K_ADDI, K_LW, K_SW: begin
                    if (k == 4) begin
                        o.srca = 2'd2; o.srcb = 3'd1; o.aluc = 3'b001; o.aluout_w = 1'b1;
                    end else if (kind == K_ADDI) begin
                        o.rb_w = 1'b1; o.m2r = 3'd5;
                    end else if (kind == K_SW) begin
                        o.iord = 2'd1; o.mem_w = 1'b1;
                    end else if (k == 5) begin
                        o.iord = 2'd1;
                    end else if (k == 6) begin
                        o.iord = 2'd1; o.mdr_w = 1'b1;
                    end else begin
                        o.rb_w = 1'b1; o.m2r = 3'd4;
                    end
                end
                K_SLT: begin
                    o.srca = 2'd2; o.aluc = 3'b111; o.rb_w = 1'b1; o.regdst = 2'd1; o.m2r = 3'd1;
                end
                K_BEQ, K_BNE: begin
                    o.srca = 2'd2; o.aluc = 3'b111; o.pcwc = 1'b1; o.pcsrc = 3'd4;
                    o.cb = (kind == K_BNE) ? 2'd1 : 2'd0;
                end
                K_J:   begin o.pc_w = 1'b1; end
                K_JAL: begin o.pc_w = 1'b1; o.rb_w = 1'b1; o.regdst = 2'd2; end
                K_JR:  begin o.pc_w = 1'b1; o.pcsrc = 3'd1; end
                K_MULT, K_DIV: begin
                    o.dom    = (kind == K_MULT);
                    o.hilo_w = (k == instr_len(kind));
                end
                K_MFHI, K_MFLO: begin
                    o.rb_w = 1'b1; o.regdst = 2'd1; o.m2r = 3'd3; o.cdm = (kind == K_MFHI);
                end
                default: ;
            endcase
        end
        return o;
    endfunction

    // Reference model: where are we in the current instruction?
    bit         m_valid = 1'b0;
    bit         m_rst   = 1'b0;
    int         m_exc   = 0;
    int         m_k     = 0;
    int         m_kind  = K_INV;
    logic [1:0] m_ec    = 2'd0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1; m_rst <= 1'b1; m_exc <= 0; m_k <= 0;
        end else if (m_valid) begin
            if (m_rst) begin
                m_rst <= 1'b0; m_k <= 1;
            end else if (m_exc != 0) begin
                if (m_exc == 3) begin m_exc <= 0; m_k <= 1; end
                else m_exc <= m_exc + 1;
            end else if (m_k == 3) begin
                if (decode(opcode, funct) == K_INV) begin m_exc <= 1; m_ec <= 2'd0; end
                else begin m_kind <= decode(opcode, funct); m_k <= 4; end
            end else if (m_k == 4 && Flag_Overflow &&
                         (m_kind == K_ADD || m_kind == K_SUB || m_kind == K_ADDI)) begin
                m_exc <= 1; m_ec <= 2'd1;
            end else if (m_k == 4 && m_kind == K_DIV && divPor0) begin
                m_exc <= 1; m_ec <= 2'd2;
            end else if (m_k >= 4 && m_k == instr_len(m_kind)) begin
                m_k <= 1;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : cmp
        out_t e;
        if (m_valid) begin
            e = expect_out(m_rst, m_exc, m_ec, m_kind, m_k);
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL model_cycle t=%0t k=%0d kind=%0d exc=%0d got=%h want=%h",
                         $time, m_k, m_kind, m_exc, act, e);
            end
        end
    end

    task automatic check(input string name, input logic [35:0] got, input logic [35:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    out_t lg [1:64];

    // Hold one instruction's inputs for n cycles starting at its fetch cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic ovf, input logic dz, input int n);
        opcode = op; funct = fn; Flag_Overflow = ovf; divPor0 = dz;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            lg[i] = act;
        end
    endtask

    logic [5:0] r_fns [9] = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h08, 6'h18, 6'h1A, 6'h10, 6'h12};
    logic [5:0] i_ops [7] = '{6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

    initial begin
        int cnt;
        int pos;
        reset = 1'b1; opcode = 6'h00; funct = 6'h00; Flag_Overflow = 1'b0; divPor0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_zero", act, 36'd0);
        end
        reset = 1'b0;

        // add, no overflow
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 5);
        check("fetch0_zero", lg[1], 36'd0);
        check("fetch1_ir_pc", {lg[2].ir_w, lg[2].pc_w}, 2'b11);
        check("add_no_early_wb", {lg[1].rb_w, lg[2].rb_w, lg[3].rb_w, lg[4].rb_w}, 4'b0000);
        check("add_wb", {lg[5].rb_w, lg[5].regdst, lg[5].m2r}, {1'b1, 2'd1, 3'd5});

        // add with overflow
        run_instr(6'h00, 6'h20, 1'b1, 1'b0, 7);
        cnt = 0;
        for (int i = 1; i <= 7; i++) cnt += int'(lg[i].rb_w);
        check("ovf_no_wb", cnt, 0);
        check("ovf_epc", {lg[5].epc_w, lg[5].ec}, {1'b1, 2'd1});
        check("ovf_vector", {lg[7].pc_w, lg[7].pcsrc}, {1'b1, 3'd5});

        // lw / sw
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 7);
        check("lw_mdr", lg[6].mdr_w, 1'b1);
        check("lw_wb", {lg[7].rb_w, lg[7].m2r, lg[7].regdst}, {1'b1, 3'd4, 2'd0});
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 5);
        check("sw_store", {lg[5].mem_w, lg[5].iord}, {1'b1, 2'd1});
        cnt = 0;
        for (int i = 1; i <= 5; i++) cnt += int'(lg[i].mem_w);
        check("sw_single_write", cnt, 1);

        // mult: one HILO_W pulse exactly N_MULT cycles after MD0 (cycle 4)
        run_instr(6'h00, 6'h18, 1'b0, 1'b0, 4 + N_MULT);
        cnt = 0; pos = 0;
        for (int i = 1; i <= 4 + N_MULT; i++) if (lg[i].hilo_w) begin cnt++; pos = i; end
        check("mult_pulses", cnt, 1);
        check("mult_distance", pos - 4, N_MULT);
        cnt = 0;
        for (int i = 4; i <= 4 + N_MULT; i++) cnt += int'(lg[i].dom);
        check("mult_divormult_held", cnt, N_MULT + 1);

        // div by zero
        run_instr(6'h00, 6'h1A, 1'b0, 1'b1, 7);
        check("dz_ec", {lg[5].epc_w, lg[5].ec}, {1'b1, 2'd2});
        cnt = 0;
        for (int i = 1; i <= 7; i++) cnt += int'(lg[i].hilo_w);
        check("dz_no_hilo", cnt, 0);

        // invalid opcode
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 6);
        check("inv_exc", {lg[4].epc_w, lg[4].ec, lg[4].iord}, {1'b1, 2'd0, 2'd2});

        // branches
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, 4);
        check("beq", {lg[4].pcwc, lg[4].cb, lg[4].pcsrc}, {1'b1, 2'd0, 3'd4});
        check("beq_only_c4", {lg[1].pcwc, lg[2].pcwc, lg[3].pcwc}, 3'b000);
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, 4);
        check("bne", {lg[4].pcwc, lg[4].cb, lg[4].pcsrc}, {1'b1, 2'd1, 3'd4});

        // reset in the middle of a multiply, then restart with jal
        run_instr(6'h00, 6'h18, 1'b0, 1'b0, 10);
        reset = 1'b1;
        @(negedge clk);
        check("md_reset_zero", act, 36'd0);
        reset = 1'b0;
        run_instr(6'h03, 6'h00, 1'b0, 1'b0, 4);
        check("restart_fetch1", lg[2].ir_w, 1'b1);
        check("jal", {lg[4].pc_w, lg[4].pcsrc, lg[4].rb_w, lg[4].regdst, lg[4].m2r},
              {1'b1, 3'd0, 1'b1, 2'd2, 3'd0});

        // Randomized phase: inputs change every cycle, model tracks the sampled ones.
        for (int c = 0; c < 4000; c++) begin
            int r;
            r = int'($urandom_range(0, 9));
            reset = ($urandom_range(0, 199) == 0);
            if (r < 4) begin
                opcode = 6'h00;
                funct  = r_fns[$urandom_range(0, 8)];
            end else if (r < 9) begin
                opcode = i_ops[$urandom_range(0, 6)];
                funct  = 6'($urandom);
            end else begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            Flag_Overflow = ($urandom_range(0, 2) == 0);
            divPor0       = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multicycle FSM that drives every control wire of the CPU datapath (PC, memory, IR, register bank, ALU, HI/LO, EPC muxes and enables).
- Sits directly upstream of the datapath. Consumes the opcode/funct fields from the IR and the datapath status flags.
- Moore machine: all outputs decode from the state register only; inputs affect only the next-state logic.

Parameters:
MULT_CYCLES, 32, cycles the multiplier needs after operands are latched in Reg_A/Reg_B
DIV_CYCLES, 32, cycles the divider needs after operands are latched

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
opcode  in  6  Instr31_26
funct  in  6  Instr15_0[5:0]
Flag_Overflow  in  1  ALU overflow
divPor0  in  1  divider divide-by-zero flag
PC_W  out  1  unconditional PC write
PCWriteCond  out  1  PC write qualified by the branch condition
PCSource  out  3  0 jump target, 1 Reg_A, 2 ALU result, 3 EPC, 4 ALU_Out_Reg, 5 loaded vector byte
IorD  out  2  0 PC, 1 ALU_Out_Reg, 2 exception vector address
Mem_W  out  1  memory write
MDR_W  out  1  MDR load
IR_W  out  1  IR load
RB_W  out  1  register bank write
regDST  out  2  0 rt, 1 rd, 2 $31
memToReg  out  3  0 PC, 1 less-than flag, 2 shifter, 3 HI/LO, 4 MDR, 5 ALU_Out_Reg
Reg_AB_W  out  1  A/B load
ALU_Out_Reg_W  out  1  ALUOut load
ALUSrcA  out  2  0 PC, 1 RAA, 2 Reg_A
ALUSrcB  out  3  0 Reg_B, 1 sign-extended imm, 2 MDR, 3 imm<<2, 4 constant 4
ALUControl  out  3  000 pass A, 001 add, 010 sub, 011 and, 111 compare
CB  out  2  0 equal, 1 not-equal, 2 greater, 3 not-greater
HILO_W  out  1  HI/LO load
divOrMult  out  1  0 divider, 1 multiplier
controlDivMult  out  1  0 LO, 1 HI
EPC_W  out  1  EPC load
EC_CTRL  out  2  0 invalid opcode, 1 overflow, 2 divide-by-zero

Behaviour:
- Reset: while reset is high at a clk edge, state goes to RESET and all outputs are 0. Reset aborts any instruction mid-flight, including the mult/div countdown. RESET lasts one cycle, then FETCH0.
- FETCH0: IorD=0. The memory read has 1-cycle latency.
- FETCH1: IR_W=1, PC_W=1, PCSource=2, ALUSrcA=0, ALUSrcB=4, ALUControl=add (PC+4).
- DECODE: Reg_AB_W=1, ALU_Out_Reg_W=1, ALUSrcA=0, ALUSrcB=3, add (branch target). Dispatch on opcode, or on funct when opcode=0.
- Supported instructions:
  - R-type: add 0x20, sub 0x22, and 0x24, slt 0x2A, jr 0x08, mult 0x18, div 0x1A, mfhi 0x10, mflo 0x12.
  - I/J-type: addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
  - Anything else goes to EXC0 with EC_CTRL=0.
- R_EXEC: ALUSrcA=2, ALUSrcB=0, op per funct, ALU_Out_Reg_W=1.
  - add/sub: if Flag_Overflow=1 at this edge, go to EXC0 with EC_CTRL=1; otherwise R_WB.
  - R_WB: RB_W=1, regDST=1, memToReg=5.
- slt: single R_SLT state with ALUControl=compare, RB_W=1, regDST=1, memToReg=1.
- addi: same flow as add with ALUSrcB=1 and regDST=0.
- lw: ADDR (A+imm into ALUOut) -> RD0 (IorD=1) -> RD1 (IorD=1, MDR_W=1) -> LW_WB (RB_W, regDST=0, memToReg=4). Total 7 cycles.
- sw: ADDR -> ST (IorD=1, Mem_W=1). Total 5 cycles.
- beq/bne: BR state, 4 cycles total, with:
  - ALUSrcA=2, ALUSrcB=0, compare;
  - PCWriteCond=1, PCSource=4, CB=0 for beq / 1 for bne.
- j: J state with PC_W=1, PCSource=0.
- jal: J state plus RB_W=1, regDST=2, memToReg=0 in the same cycle; the bank captures the old PC (already PC+4).
- jr: PC_W=1, PCSource=1.
- mult/div:
  - MD0: divOrMult set and held for the whole operation; counter loaded with MULT_CYCLES or DIV_CYCLES.
  - div with divPor0=1 at MD0 goes to EXC0 with EC_CTRL=2, and HILO_W never pulses.
  - MD_WAIT decrements the counter. When it reaches 1, go to MD_DONE: HILO_W=1 for exactly one cycle.
  - The MD0-to-HILO_W distance is exactly N cycles.
- mfhi/mflo: RB_W=1, regDST=1, memToReg=3, controlDivMult=1 for HI / 0 for LO.
- Exceptions: EC_CTRL is held from EXC0 through EXC2.
  - EXC0: EPC_W=1, IorD=2.
  - EXC1: IorD=2, MDR_W=1.
  - EXC2: PC_W=1, PCSource=5, then FETCH0.
- Every terminal state returns to FETCH0. No state is entered twice without passing FETCH0, except MD_WAIT.

Test Plan:
- Reset held 3 cycles -> all outputs 0. After release: RESET, FETCH0, then IR_W=PC_W=1 on the 3rd cycle.
- opcode=0, funct=0x20, Flag_Overflow=0 -> RB_W=1, regDST=1, memToReg=5 only in cycle 5, then FETCH0.
- Same add with Flag_Overflow=1 at R_EXEC -> RB_W never asserts; EPC_W=1 with EC_CTRL=1 next cycle; PC_W with PCSource=5 two cycles later.
- lw -> MDR_W in cycle 6, then RB_W/memToReg=4/regDST=0 in cycle 7. sw -> Mem_W=1 with IorD=1 in cycle 5 only.
- mult with MULT_CYCLES=32 -> single HILO_W pulse 32 cycles after MD0, divOrMult=1 throughout. div with divPor0=1 -> EC_CTRL=2, no HILO_W. Reset during MD_WAIT -> outputs 0, restart at FETCH0.
- opcode=0x3F -> exception with EC_CTRL=0. beq -> PCWriteCond=1, CB=0, PCSource=4 in cycle 4 only; bne -> CB=1.
